// File: rtl/twos_complement_serial.sv
// Serial two's-complement unit: pass, negate, abs and sign-magnitude conversion,
// processed CHUNK bits per clock (LSB chunk first) through a registered carry.
module twos_complement_serial #(
    parameter int WIDTH = 6,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] x,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0]    K_LAST   = KW'(N - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] x_reg;
    logic [1:0]       mode_reg;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_fix;
    logic             carry;
    logic [KW-1:0]    k;
    logic             neg;
    logic             accept;
    logic             last;
    logic [CHUNK-1:0] x_chunk;
    logic [CHUNK-1:0] add_a;
    logic [CHUNK:0]   sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new op may be accepted from IDLE or directly out of the one-cycle DONE state.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    state_next = RUN;
                    accept     = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Negation is ~x + 1; the +1 enters as the initial carry and ripples chunk to chunk.
    always_comb begin
        last     = (k == K_LAST);
        neg      = (mode_reg == 2'b01) | (mode_reg[1] & x_reg[WIDTH-1]);
        x_chunk  = x_reg[k*CHUNK +: CHUNK];
        add_a    = neg ? ~x_chunk : x_chunk;
        sum      = {1'b0, add_a} + {{CHUNK{1'b0}}, neg & carry};
        res_next = res;
        res_next[k*CHUNK +: CHUNK] = sum[CHUNK-1:0];
        res_fix  = res_next;
        if (mode_reg == 2'b11) begin
            res_fix[WIDTH-1] = x_reg[WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_reg    <= '0;
            mode_reg <= '0;
            res      <= '0;
            carry    <= 1'b0;
            k        <= '0;
            y        <= '0;
            ovf      <= 1'b0;
        end else if (accept) begin
            x_reg    <= x;
            mode_reg <= mode;
            carry    <= 1'b1;
            k        <= '0;
        end else if (state == RUN) begin
            res   <= res_next;
            carry <= sum[CHUNK];
            if (last) begin
                y   <= res_fix;
                ovf <= (mode_reg != 2'b00) && (x_reg == MOST_NEG);
            end else begin
                k <= k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_twos_complement_serial.sv
// Bench for twos_complement_serial: three instances (CHUNK=2,1,6) against an
// arithmetic reference model, plus directed literal checks.
module tb_twos_complement_serial;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] x = '0;

    logic         dut_busy [3];
    logic         dut_done [3];
    logic [W-1:0] dut_y    [3];
    logic         dut_ovf  [3];

    int m_left [3];
    logic         m_done [3];
    logic [W-1:0] m_y    [3];
    logic         m_ovf  [3];
    logic [W:0]   m_pend [3];

    int  errors = 0;
    int  checks = 0;
    bit  checking = 1'b0;

    always #5 clk = ~clk;

    twos_complement_serial #(.WIDTH(W), .CHUNK(2)) dut_c2 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x),
        .busy(dut_busy[0]), .done(dut_done[0]), .y(dut_y[0]), .ovf(dut_ovf[0]));
    twos_complement_serial #(.WIDTH(W), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x),
        .busy(dut_busy[1]), .done(dut_done[1]), .y(dut_y[1]), .ovf(dut_ovf[1]));
    twos_complement_serial #(.WIDTH(W), .CHUNK(6)) dut_c6 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .x(x),
        .busy(dut_busy[2]), .done(dut_done[2]), .y(dut_y[2]), .ovf(dut_ovf[2]));

    function automatic int nOf(int i);
        return (i == 0) ? 3 : (i == 1) ? 6 : 1;
    endfunction

    // Reference result {ovf, y} from plain signed arithmetic.
    function automatic logic [W:0] refOp(logic [1:0] md, logic [W-1:0] xv);
        int v;
        int r;
        logic [W-1:0] yv;
        logic o;
        v = $signed(xv);
        case (md)
            2'd0:    r = v;
            2'd1:    r = -v;
            default: r = (v < 0) ? -v : v;
        endcase
        yv = W'(r);
        if (md == 2'd3 && v < 0) yv[W-1] = 1'b1;
        o = (md != 2'd0) && (v == -(1 << (W-1)));
        return {o, yv};
    endfunction

    // Timing model: an accepted op occupies N cycles, then done and the result appear.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_left[i] <= 0;
                m_done[i] <= 1'b0;
                m_y[i]    <= '0;
                m_ovf[i]  <= 1'b0;
                m_pend[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_done[i] <= (m_left[i] == 1);
                if (m_left[i] == 1) begin
                    m_y[i]   <= m_pend[i][W-1:0];
                    m_ovf[i] <= m_pend[i][W];
                end
                if (m_left[i] != 0) begin
                    m_left[i] <= m_left[i] - 1;
                end else if (start) begin
                    m_left[i] <= nOf(i);
                    m_pend[i] <= refOp(mode, x);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W:0] act, input logic [W:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkFlag(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            for (int i = 0; i < 3; i++) begin
                checkFlag($sformatf("busy[%0d]", i), dut_busy[i], m_left[i] != 0);
                checkFlag($sformatf("done[%0d]", i), dut_done[i], m_done[i]);
                checkOutput($sformatf("y[%0d]", i), {1'b0, dut_y[i]}, {1'b0, m_y[i]});
                checkFlag($sformatf("ovf[%0d]", i), dut_ovf[i], m_ovf[i]);
            end
        end
    end

    task automatic waitIdle();
        int cnt = 0;
        @(negedge clk);
        while ((dut_busy[0] | dut_busy[1] | dut_busy[2]) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: busy still high after %0d cycles", cnt);
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [1:0] md, input logic [W-1:0] xv);
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        x     = xv;
        @(negedge clk);
        start = 1'b0;
        waitIdle();
    endtask

    task automatic checkAll(input string name, input logic [W:0] exp);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("%s_%0d", name, i), {dut_ovf[i], dut_y[i]}, exp);
    endtask

    initial begin
        int lat [3];
        bit got [3];
        int gap;
        int first_done;
        int dcount;

        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checkFlag($sformatf("rst_busy_%0d", i), dut_busy[i], 1'b0);
            checkFlag($sformatf("rst_done_%0d", i), dut_done[i], 1'b0);
        end
        checkAll("rst_y", 7'b0_000000);
        rst = 1'b0;
        checking = 1'b1;

        checkOutput("ref_neg5",   refOp(2'd1, 6'b000101), 7'b0_111011);
        checkOutput("ref_abs_m5", refOp(2'd2, 6'b111011), 7'b0_000101);
        checkOutput("ref_sm_m5",  refOp(2'd3, 6'b111011), 7'b0_100101);
        checkOutput("ref_neg_mn", refOp(2'd1, 6'b100000), 7'b1_100000);
        checkOutput("ref_pass_mn", refOp(2'd0, 6'b100000), 7'b0_100000);
        checkOutput("ref_neg0",   refOp(2'd1, 6'b000000), 7'b0_000000);

        applyStimulus(2'b01, 6'b000101); checkAll("neg5",     7'b0_111011);
        applyStimulus(2'b10, 6'b111011); checkAll("abs_m5",   7'b0_000101);
        applyStimulus(2'b11, 6'b111011); checkAll("sm_m5",    7'b0_100101);
        applyStimulus(2'b01, 6'b100000); checkAll("neg_mn",   7'b1_100000);
        applyStimulus(2'b10, 6'b100000); checkAll("abs_mn",   7'b1_100000);
        applyStimulus(2'b11, 6'b100000); checkAll("sm_mn",    7'b1_100000);
        applyStimulus(2'b00, 6'b100000); checkAll("pass_mn",  7'b0_100000);
        applyStimulus(2'b01, 6'b000000); checkAll("neg0",     7'b0_000000);
        applyStimulus(2'b11, 6'b010110); checkAll("sm_pos",   7'b0_010110);

        // Latency from accept edge to done, per chunk size.
        @(negedge clk);
        start = 1'b1; mode = 2'b01; x = 6'b000101;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkFlag($sformatf("busy_after_accept_%0d", i), dut_busy[i], 1'b1);
            got[i] = 1'b0;
            lat[i] = 0;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++)
                if (!got[i] && dut_done[i]) begin
                    got[i] = 1'b1;
                    lat[i] = cyc;
                end
        end
        checkOutput("latency_c2", 7'(lat[0]), 7'd3);
        checkOutput("latency_c1", 7'(lat[1]), 7'd6);
        checkOutput("latency_c6", 7'(lat[2]), 7'd1);
        waitIdle();

        // Back-to-back with start held; x changes mid-RUN and is latched only at the second accept.
        @(negedge clk);
        start = 1'b1; mode = 2'b01; x = 6'b000101;
        @(negedge clk);
        x = 6'b000011;
        gap = 0;
        first_done = -1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (dut_done[0]) begin
                if (first_done < 0) begin
                    first_done = cyc;
                end else begin
                    gap = cyc - first_done;
                    start = 1'b0;
                    break;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("b2b_gap", 7'(gap), 7'd4);
        checkOutput("b2b_y2", {dut_ovf[0], dut_y[0]}, 7'b0_111101);
        waitIdle();

        // Asynchronous reset one edge into an op.
        @(negedge clk);
        start = 1'b1; mode = 2'b01; x = 6'b000101;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkFlag($sformatf("arst_busy_%0d", i), dut_busy[i], 1'b0);
            checkFlag($sformatf("arst_done_%0d", i), dut_done[i], 1'b0);
        end
        checkAll("arst_y", 7'b0_000000);
        @(negedge clk);
        rst = 1'b0;
        dcount = 0;
        repeat (10) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (dut_done[i]) dcount++;
        end
        checkOutput("no_done_after_reset", 7'(dcount), 7'd0);

        for (int m = 0; m < 4; m++)
            for (int v = 0; v < 64; v++)
                applyStimulus(2'(m), 6'(v));

        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
